// File: rtl/ip_mem_loader.sv
// Streams instruction words into the IP memory at BCD addresses, with optional read-back verify.
// Latency: 4 cycles per word (FETCH, WRITE, 2 wait) with a 2-cycle memory, 7 with verify.
// Backpressure: data_ready_o is high only in FETCH; a word offered at any other time is held upstream.
module ip_mem_loader #(
    parameter int DIGITS         = 6,
    parameter int DEKATRON_WIDTH = 4,
    parameter int INSN_WIDTH     = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             start_i,
    input  logic [DIGITS*DEKATRON_WIDTH-1:0] start_addr_i,
    input  logic                             verify_i,
    input  logic                             data_valid_i,
    input  logic [INSN_WIDTH-1:0]            data_in_i,
    input  logic                             data_last_i,
    output logic                             data_ready_o,
    output logic                             mem_request_o,
    output logic                             mem_we_o,
    output logic [DIGITS*DEKATRON_WIDTH-1:0] mem_address_o,
    output logic [INSN_WIDTH-1:0]            mem_insn_in_o,
    input  logic                             mem_ready_i,
    input  logic [INSN_WIDTH-1:0]            mem_insn_out_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic [1:0]                       err_code_o,
    output logic [DIGITS*DEKATRON_WIDTH-1:0] err_addr_o
);

    localparam int DW = DEKATRON_WIDTH;
    localparam int AW = DIGITS * DEKATRON_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] NINE = DW'(9);
    localparam logic [DW-1:0] ONE  = DW'(1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_VERIFY   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ADDRESS  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WRITE, S_WAIT_W, S_READ, S_WAIT_R, S_DONE, S_ERROR
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         addr_q;
    logic [INSN_WIDTH-1:0] word_q;
    logic                  last_q;
    logic                  verify_q;
    logic [TW-1:0]         tcnt_q;
    logic                  data_ready_q;
    logic                  mem_request_q;
    logic                  mem_we_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [1:0]            err_code_q;
    logic [AW-1:0]         err_addr_q;

    logic                  start_bad_d;
    logic                  addr_max_d;
    logic [AW-1:0]         addr_inc_d;
    logic                  carry_d;

    // Digit validation of the start address, all-nines detect and ripple-carry BCD increment.
    always_comb begin
        start_bad_d = 1'b0;
        addr_max_d  = 1'b1;
        addr_inc_d  = addr_q;
        carry_d     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (start_addr_i[i*DW +: DW] > NINE) begin
                start_bad_d = 1'b1;
            end
            if (addr_q[i*DW +: DW] != NINE) begin
                addr_max_d = 1'b0;
            end
            if (carry_d) begin
                if (addr_q[i*DW +: DW] == NINE) begin
                    addr_inc_d[i*DW +: DW] = '0;
                end else begin
                    addr_inc_d[i*DW +: DW] = addr_q[i*DW +: DW] + ONE;
                    carry_d = 1'b0;
                end
            end
        end
    end

    // Loader FSM; every output is a register updated on the transition into the state that drives it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            word_q        <= '0;
            last_q        <= 1'b0;
            verify_q      <= 1'b0;
            tcnt_q        <= '0;
            data_ready_q  <= 1'b0;
            mem_request_q <= 1'b0;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_addr_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (start_bad_d) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_ADDRESS;
                            err_addr_q <= start_addr_i;
                            state_q    <= S_ERROR;
                        end else begin
                            addr_q       <= start_addr_i;
                            verify_q     <= verify_i;
                            error_q      <= 1'b0;
                            err_code_q   <= ERR_NONE;
                            busy_q       <= 1'b1;
                            data_ready_q <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (data_valid_i) begin
                        word_q        <= data_in_i;
                        last_q        <= data_last_i;
                        data_ready_q  <= 1'b0;
                        mem_request_q <= 1'b1;
                        mem_we_q      <= 1'b1;
                        state_q       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_request_q <= 1'b0;
                    mem_we_q      <= 1'b0;
                    tcnt_q        <= '0;
                    state_q       <= S_WAIT_W;
                end
                S_READ: begin
                    mem_request_q <= 1'b0;
                    tcnt_q        <= '0;
                    state_q       <= S_WAIT_R;
                end
                S_WAIT_W, S_WAIT_R: begin
                    if (mem_ready_i) begin
                        if (state_q == S_WAIT_W && verify_q) begin
                            mem_request_q <= 1'b1;
                            state_q       <= S_READ;
                        end else if (state_q == S_WAIT_R && mem_insn_out_i != word_q) begin
                            error_q    <= 1'b1;
                            err_code_q <= ERR_VERIFY;
                            err_addr_q <= addr_q;
                            busy_q     <= 1'b0;
                            state_q    <= S_ERROR;
                        end else if (last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else if (addr_max_d) begin
                            // More words remain but the address space is exhausted.
                            error_q    <= 1'b1;
                            err_code_q <= ERR_ADDRESS;
                            err_addr_q <= addr_q;
                            busy_q     <= 1'b0;
                            state_q    <= S_ERROR;
                        end else begin
                            addr_q       <= addr_inc_d;
                            data_ready_q <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        err_addr_q <= addr_q;
                        busy_q     <= 1'b0;
                        state_q    <= S_ERROR;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERROR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_ready_o  = data_ready_q;
    assign mem_request_o = mem_request_q;
    assign mem_we_o      = mem_we_q;
    assign mem_address_o = addr_q;
    assign mem_insn_in_o = word_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign err_code_o    = err_code_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_ip_mem_loader.sv
// Bench for ip_mem_loader: behavioural memory, directed table, randomized loads against a reference model.
// Latency is checked through busy-cycle counts on the directed vectors.
// Upstream source holds each word until the valid/ready transfer is observed.
module tb_ip_mem_loader;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] start_addr;
    logic        verify;
    logic        data_valid;
    logic [3:0]  data_in;
    logic        data_last;
    logic        data_ready;
    logic        mem_request;
    logic        mem_we;
    logic [23:0] mem_address;
    logic [3:0]  mem_insn_in;
    logic        mem_ready = 1'b0;
    logic [3:0]  mem_insn_out = 4'h0;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [23:0] err_addr;

    always #5 clk = ~clk;

    ip_mem_loader #(.DIGITS(6), .DEKATRON_WIDTH(4), .INSN_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
        .verify_i(verify), .data_valid_i(data_valid), .data_in_i(data_in),
        .data_last_i(data_last), .data_ready_o(data_ready), .mem_request_o(mem_request),
        .mem_we_o(mem_we), .mem_address_o(mem_address), .mem_insn_in_o(mem_insn_in),
        .mem_ready_i(mem_ready), .mem_insn_out_i(mem_insn_out), .busy_o(busy),
        .done_o(done), .error_o(error), .err_code_o(err_code), .err_addr_o(err_addr)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural memory ----------------
    logic [3:0]  mem_arr [logic [23:0]];
    logic [23:0] wr_addr_q[$];
    logic [3:0]  wr_data_q[$];
    int          rd_cnt = 0;
    int          proto_bad = 0;
    int          lat_max = 0;
    bit          stuck = 1'b0;
    bit          corrupt_en = 1'b0;
    logic [23:0] corrupt_addr = '0;
    bit          pending = 1'b0;
    int          wait_cnt = 0;
    logic [3:0]  rd_data = '0;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (mem_we && !mem_request) proto_bad++;
            if (mem_request) begin
                if (pending) proto_bad++;
                if (mem_we) begin
                    mem_arr[mem_address] = mem_insn_in;
                    wr_addr_q.push_back(mem_address);
                    wr_data_q.push_back(mem_insn_in);
                end else begin
                    rd_cnt++;
                    if (corrupt_en && mem_address == corrupt_addr) rd_data = 4'h0;
                    else if (mem_arr.exists(mem_address)) rd_data = mem_arr[mem_address];
                    else rd_data = 4'h0;
                end
                pending  = !stuck;
                wait_cnt = 1 + int'($urandom_range(0, lat_max));
            end else if (pending) begin
                if (wait_cnt == 0) begin
                    mem_ready    = 1'b1;
                    mem_insn_out = rd_data;
                    pending      = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- helpers and reference model ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [23:0] b);
        int v = 0;
        for (int i = 5; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [23:0] int2bcd(input int a);
        logic [23:0] r = '0;
        int x = a;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [23:0] b);
        for (int i = 0; i < 6; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    logic [3:0]  words[8];
    logic [23:0] m_wa[$];
    logic [3:0]  m_wd[$];
    int          m_reads;
    int          m_done;
    int          m_code;
    logic [23:0] m_erraddr;

    // Sequential address walk over plain integers: what should be written, read and reported.
    task automatic ref_model(input logic [23:0] sa, input bit vf, input int n,
                             input bit cen, input logic [23:0] ca, input bit stk);
        int a;
        logic [23:0] ab;
        m_wa.delete(); m_wd.delete();
        m_reads = 0; m_done = 0; m_code = 0; m_erraddr = '0;
        if (!bcd_ok(sa)) begin m_code = 3; m_erraddr = sa; return; end
        a = bcd2int(sa);
        for (int i = 0; i < n; i++) begin
            ab = int2bcd(a);
            m_wa.push_back(ab);
            m_wd.push_back(words[i]);
            if (stk) begin m_code = 2; m_erraddr = ab; return; end
            if (vf) begin
                m_reads++;
                if (cen && ab == ca && words[i] != 4'h0) begin m_code = 1; m_erraddr = ab; return; end
            end
            if (i == n - 1) begin m_done = 1; return; end
            if (a == 999999) begin m_code = 3; m_erraddr = ab; return; end
            a++;
        end
    endtask

    // ---------------- load driver / monitor ----------------
    int wr_base, rd_base, pb_base;
    int res_busy, res_done, res_req_after, res_timed_out;
    int res_err, res_code, res_busy_end;
    logic [23:0] res_erraddr;

    task automatic run_load(input logic [23:0] sa, input bit vf, input int n,
                            input bit gaps, input bit stray);
        int idx = 0;
        int cyc = 0;
        int tail = 0;
        bit rdy;
        bit ended = 1'b0;
        wr_base = wr_addr_q.size(); rd_base = rd_cnt; pb_base = proto_bad;
        res_busy = 0; res_done = 0; res_req_after = 0; res_timed_out = 0;
        @(posedge clk); #1;
        start_addr = sa; verify = vf; start = 1'b1;
        data_valid = 1'b1; data_in = words[0]; data_last = (n == 1);
        @(posedge clk); #1;
        start = 1'b0;
        while (tail < 4 && cyc < 3000) begin
            @(negedge clk);
            rdy = data_ready;
            if (busy) res_busy++;
            if (done) res_done++;
            if (ended && mem_request) res_req_after++;
            if (done || error) ended = 1'b1;
            if (ended) tail++;
            @(posedge clk); #1;
            start = 1'b0;
            if (data_valid && rdy) begin idx++; data_valid = 1'b0; end
            if (!data_valid && idx < n && (!gaps || $urandom_range(0, 2) != 0)) begin
                data_valid = 1'b1; data_in = words[idx]; data_last = (idx == n - 1);
            end
            if (stray && busy && !ended && $urandom_range(0, 7) == 0) begin
                start = 1'b1; start_addr = 24'hFFFFFF;
            end
            cyc++;
        end
        if (cyc >= 3000) res_timed_out = 1;
        data_valid = 1'b0; start = 1'b0;
        res_err = int'(error); res_code = int'(err_code);
        res_erraddr = err_addr; res_busy_end = int'(busy);
    endtask

    task automatic compare_run(input string tag);
        int nwr = wr_addr_q.size() - wr_base;
        chk({tag, "_no_hang"}, res_timed_out, 0);
        chk({tag, "_done_pulses"}, res_done, m_done);
        chk({tag, "_error"}, res_err, (m_code != 0));
        chk({tag, "_err_code"}, res_code, m_code);
        if (m_code != 0) chk({tag, "_err_addr"}, res_erraddr, m_erraddr);
        chk({tag, "_n_writes"}, nwr, m_wa.size());
        for (int i = 0; i < nwr && i < m_wa.size(); i++)
            chk($sformatf("%s_write%0d", tag, i),
                {wr_addr_q[wr_base + i], wr_data_q[wr_base + i]}, {m_wa[i], m_wd[i]});
        chk({tag, "_n_reads"}, rd_cnt - rd_base, m_reads);
        chk({tag, "_protocol"}, proto_bad - pb_base, 0);
        chk({tag, "_quiet_after_end"}, res_req_after, 0);
        chk({tag, "_busy_end"}, res_busy_end, 0);
    endtask

    typedef struct {
        logic [23:0] sa;
        bit          vf;
        int          n;
        bit          cen;
        logic [23:0] ca;
        bit          stk;
        int          exp_done;
        int          exp_code;
        logic [23:0] exp_err_addr;
        int          exp_busy;
        int          exp_nwr;
        logic [23:0] exp_last_wa;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        logic [23:0] sa;
        int a, n, r, k;
        bit vf, cen, stk;

        vecs[0] = '{24'h000998, 1'b0, 3, 1'b0, 24'h0,      1'b0, 1, 0, 24'h0,      12, 3, 24'h001000};
        vecs[1] = '{24'h000998, 1'b1, 3, 1'b0, 24'h0,      1'b0, 1, 0, 24'h0,      21, 3, 24'h001000};
        vecs[2] = '{24'h000998, 1'b1, 3, 1'b1, 24'h000999, 1'b0, 0, 1, 24'h000999, 14, 2, 24'h000999};
        vecs[3] = '{24'h000998, 1'b0, 3, 1'b0, 24'h0,      1'b1, 0, 2, 24'h000998, 2 + TIMEOUT, 1, 24'h000998};
        vecs[4] = '{24'h0A0000, 1'b0, 3, 1'b0, 24'h0,      1'b0, 0, 3, 24'h0A0000, 0, 0, 24'h0};
        vecs[5] = '{24'h999999, 1'b0, 2, 1'b0, 24'h0,      1'b0, 0, 3, 24'h999999, 4, 1, 24'h999999};
        vecs[6] = '{24'h999999, 1'b1, 1, 1'b0, 24'h0,      1'b0, 1, 0, 24'h0,      7, 1, 24'h999999};

        rst_n = 1'b0; start = 1'b0; start_addr = '0; verify = 1'b0;
        data_valid = 1'b0; data_in = '0; data_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {data_ready, mem_request, mem_we, mem_address, mem_insn_in,
                              busy, done, error, err_code, err_addr}, 64'h0);
        rst_n = 1'b1;

        // Directed table: stream 3, 7, A with a memory that answers in 2 cycles.
        words[0] = 4'h3; words[1] = 4'h7; words[2] = 4'hA;
        for (int t = 0; t < 7; t++) begin
            lat_max = 0; stuck = vecs[t].stk;
            corrupt_en = vecs[t].cen; corrupt_addr = vecs[t].ca;
            ref_model(vecs[t].sa, vecs[t].vf, vecs[t].n, vecs[t].cen, vecs[t].ca, vecs[t].stk);
            run_load(vecs[t].sa, vecs[t].vf, vecs[t].n, 1'b0, 1'b0);
            compare_run($sformatf("vec%0d", t));
            chk($sformatf("vec%0d_busy_cycles", t), res_busy, vecs[t].exp_busy);
            chk($sformatf("vec%0d_tbl_done", t), res_done, vecs[t].exp_done);
            chk($sformatf("vec%0d_tbl_code", t), res_code, vecs[t].exp_code);
            if (vecs[t].exp_code != 0) chk($sformatf("vec%0d_tbl_err_addr", t), res_erraddr, vecs[t].exp_err_addr);
            chk($sformatf("vec%0d_tbl_nwr", t), wr_addr_q.size() - wr_base, vecs[t].exp_nwr);
            if (vecs[t].exp_nwr > 0 && wr_addr_q.size() > wr_base)
                chk($sformatf("vec%0d_tbl_last_addr", t), wr_addr_q[wr_addr_q.size() - 1], vecs[t].exp_last_wa);
        end
        stuck = 1'b0; corrupt_en = 1'b0;

        // Asynchronous reset while waiting for read data.
        lat_max = 0;
        rd_base = rd_cnt;
        @(posedge clk); #1;
        start_addr = 24'h000998; verify = 1'b1; start = 1'b1;
        data_valid = 1'b1; data_in = 4'h3; data_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (rd_cnt == rd_base && cyc < 100) begin @(negedge clk); cyc++; end
        chk("rst_reached_read", (cyc < 100), 1);
        @(posedge clk); #1;
        chk("rst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_cleared", {data_ready, mem_request, mem_we, mem_address, mem_insn_in,
                                    busy, done, error, err_code, err_addr}, 64'h0);
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        words[0] = 4'h5; words[1] = 4'hC;
        ref_model(24'h123458, 1'b1, 2, 1'b0, 24'h0, 1'b0);
        run_load(24'h123458, 1'b1, 2, 1'b0, 1'b0);
        compare_run("after_reset");

        // Randomized loads: gaps on the input stream, variable memory latency, stray Starts.
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) words[i] = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 7) a = $urandom_range(0, 999999);
            else a = 999999 - int'($urandom_range(0, 4));
            sa = int2bcd(a);
            if (r == 9) begin
                k = $urandom_range(0, 5);
                sa[k*4 +: 4] = 4'($urandom_range(10, 15));
            end
            vf  = ($urandom_range(0, 1) == 1);
            cen = ($urandom_range(0, 3) == 0);
            stk = ($urandom_range(0, 15) == 0);
            lat_max = $urandom_range(0, 2);
            stuck = stk; corrupt_en = cen;
            corrupt_addr = int2bcd(a + int'($urandom_range(0, n - 1)));
            ref_model(sa, vf, n, cen, corrupt_addr, stk);
            run_load(sa, vf, n, 1'b1, 1'b1);
            compare_run($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
